dm_bcd_scan: RTL and testbench

//  Parametrised successor to the display manager. Converts a DATA_W-bit binary value to N_DIG decimal digits

---
 rtl/dm_bcd_scan.sv | 141 ++++++++++++++
 tb/tb_dm_bcd_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_bcd_scan.sv
// Binary-to-BCD converter (sequential double-dabble) with a built-in 8-digit 7-segment scanner.
// Optional leading-zero blanking is enabled by defining DM_LZ_BLANK_EN.
module dm_bcd_scan #(
  parameter int DATA_W      = 16,
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        prog,
  input  logic [1:0]        modulo,
  output logic              busy,
  output logic              valid,
  output logic              ovf,
  output logic [7:0]        an,
  output logic [7:0]        dec_ddp
);
  localparam int BW = 4 * N_DIG;
  localparam int CW = $clog2(DATA_W);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [31:0] LIMIT = 32'(10 ** N_DIG);

  // Handshake: load is accepted only in IDLE; busy is high while shifting,
  // valid pulses for one cycle when the new digits and ovf are committed.
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     digits;
  logic [CW-1:0]     cnt;
  logic              ovf_pend;

  logic [RW-1:0]     rcnt;
  logic [2:0]        pos;
  logic [BW-1:0]     upper;
  logic [7:0]        cur_seg;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_comb begin
    adj = bcd;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      bcd      <= '0;
      digits   <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      valid <= 1'b0;
      busy  <= (state == CONV);
      case (state)
        IDLE: begin
          if (load) begin
            sh       <= data_in;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= (32'(data_in) >= LIMIT);
            state    <= CONV;
          end
        end
        CONV: begin
          // Carry out of the top digit falls off the left end.
          {bcd, sh} <= {adj[BW-2:0], sh, 1'b0};
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          digits <= bcd;
          ovf    <= ovf_pend;
          valid  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    upper   = digits >> {pos, 2'b00};
    cur_seg = 8'hFF;
    if (int'(pos) < N_DIG) begin
      if (ovf) cur_seg = 8'hBF;
`ifdef DM_LZ_BLANK_EN
      else if (pos != 3'd0 && upper == '0) cur_seg = 8'hFF;
`endif
      else cur_seg = seg7(upper[3:0]);
    end else if (pos == 3'd5) begin
      cur_seg = seg7({2'b00, modulo});
    end else if (pos == 3'd7) begin
      cur_seg = seg7({1'b0, prog});
    end
  end

  // an and dec_ddp are registered from the same pos so they always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt    <= '0;
      pos     <= '0;
      an      <= 8'hFF;
      dec_ddp <= 8'hFF;
    end else begin
      an      <= ~(8'b1 << pos);
      dec_ddp <= cur_seg;
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        pos  <= pos + 3'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_bcd_scan.sv
// Directed and randomized bench for dm_bcd_scan with a digit-arithmetic reference model.
module tb_dm_bcd_scan;
  localparam int DATA_W = 16;
  localparam int N_DIG  = 4;
  localparam int RDIV   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [2:0]        prog;
  logic [1:0]        modulo;
  logic              busy, valid, ovf;
  logic [7:0]        an, dec_ddp;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  dm_bcd_scan #(.DATA_W(DATA_W), .N_DIG(N_DIG), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .prog(prog),
    .modulo(modulo), .busy(busy), .valid(valid), .ovf(ovf), .an(an),
    .dec_ddp(dec_ddp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected segment pattern for a position, given the last committed value.
  function automatic logic [7:0] model_seg(input int p, input int unsigned v,
                                           input int pr, input int md);
    int unsigned pw;
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < N_DIG; i++) lim = lim * 10;
    if (p < N_DIG) begin
      if (v >= lim) return 8'hBF;
      pw = 1;
      for (int i = 0; i < p; i++) pw = pw * 10;
`ifdef DM_LZ_BLANK_EN
      if (p > 0 && v < pw) return 8'hFF;
`endif
      return seg_tbl[(v / pw) % 10];
    end
    if (p == 5) return seg_tbl[md];
    if (p == 7) return seg_tbl[pr];
    return 8'hFF;
  endfunction

  task automatic wait_pos(input int p, output logic [7:0] s);
    logic [7:0] tgt;
    int n;
    tgt = ~(8'(1) << p);
    n = 0;
    while (an !== tgt && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("scan_reach_p%0d", p), an, tgt);
    s = dec_ddp;
  endtask

  task automatic check_display(input int unsigned v);
    logic [7:0] s;
    for (int p = 0; p < 8; p++) begin
      wait_pos(p, s);
      chk($sformatf("seg_p%0d_v%0d", p, v), s, model_seg(p, v, int'(prog), int'(modulo)));
    end
  endtask

  // Loads v; if inj_at >= 0 a second load of 9999 is attempted that many cycles in.
  task automatic do_conv(input int unsigned v, input int inj_at);
    int n;
    int bcnt;
    data_in = DATA_W'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    data_in = DATA_W'($urandom);
    n = 0;
    bcnt = 0;
    while (!valid && n < 40) begin
      if (n == inj_at) begin
        load = 1'b1;
        data_in = 16'd9999;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      n++;
      if (busy) bcnt++;
    end
    load = 1'b0;
    chk($sformatf("latency_v%0d", v), n, 17);
    chk($sformatf("busy_cycles_v%0d", v), bcnt, DATA_W);
    chk("busy_at_valid", busy, 1'b0);
    chk($sformatf("ovf_v%0d", v), ovf, (v >= 10000) ? 1'b1 : 1'b0);
    @(negedge clk);
    chk("valid_one_cycle", valid, 1'b0);
  endtask

  initial begin
    logic [7:0] s;
    int vcount;
    int unsigned v;
    rst = 1'b1;
    load = 1'b0;
    data_in = '0;
    prog = 3'd5;
    modulo = 2'd2;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_an", an, 8'hFF);
    chk("rst_dec", dec_ddp, 8'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_pos0", an, 8'hFE);
    check_display(0);

    // 1234 conversion and exact digit codes
    do_conv(1234, -1);
    wait_pos(0, s); chk("t1_p0", s, 8'h99);
    wait_pos(1, s); chk("t1_p1", s, 8'hB0);
    wait_pos(2, s); chk("t1_p2", s, 8'hA4);
    wait_pos(3, s); chk("t1_p3", s, 8'hF9);

    // Overflow then recovery
    do_conv(12345, -1);
    check_display(12345);
    do_conv(42, -1);
    check_display(42);

    // Load while busy is ignored
    do_conv(1234, 5);
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("t3_extra_valid", vcount, 0);
    check_display(1234);

    // Reset mid-conversion
    data_in = 16'd4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_an", an, 8'hFF);
    chk("t4_dec", dec_ddp, 8'hFF);
    chk("t4_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("t4_no_valid", vcount, 0);
    wait_pos(0, s); chk("t4_p0", s, 8'hC0);
    check_display(0);

    // Leading-zero cases
    do_conv(7, -1);
    check_display(7);
    do_conv(0, -1);
    check_display(0);

    // Fixed positions and anode wrap
    prog = 3'd5;
    modulo = 2'd2;
    wait_pos(5, s); chk("t6_mod", s, 8'hA4);
    wait_pos(6, s); chk("t6_p6", s, 8'hFF);
    wait_pos(7, s); chk("t6_prog", s, 8'h92);
    vcount = 0;
    while (an === 8'h7F && vcount < 20) begin
      @(negedge clk);
      vcount++;
    end
    chk("t6_wrap", an, 8'hFE);
    wait_pos(4, s); chk("t6_p4", s, 8'hFF);

    // Randomized values, back to back
    for (int k = 0; k < 10; k++) begin
      prog = 3'($urandom_range(0, 7));
      modulo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) v = $urandom_range(10000, 65535);
      else v = $urandom_range(0, 9999);
      do_conv(v, -1);
      check_display(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
